// File: rtl/led_matrix_pkg.sv
// Shared constants and types for the LED matrix frame store.
// No logic; latency and backpressure do not apply.
package led_matrix_pkg;
    localparam int DEF_COLS   = 64;
    localparam int DEF_ROWS   = 32;
    localparam int DEF_PIX_W  = 4;
    localparam int DEF_WORD_W = 32;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    typedef logic [DEF_PIX_W-1:0] pixel_t;
endpackage

// File: rtl/fb_half_ram.sv
// One half-frame of pixels: word-wide write port, pixel-wide read port.
// Read latency 1 cycle; no backpressure, a write is taken whenever we_i is high.
module fb_half_ram #(
    parameter  int WORD_W = 32,
    parameter  int PIX_W  = 4,
    parameter  int WORDS  = 128,
    parameter  int WA_W   = 7,
    parameter  int PA_W   = 10,
    localparam int PPW    = WORD_W / PIX_W,
    localparam int SEL_W  = (PPW > 1) ? $clog2(PPW) : 1
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [WA_W-1:0]   waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [PA_W-1:0]   raddr_i,
    output logic [PIX_W-1:0]  rdata_o
);
    localparam logic [PA_W-1:0] PPW_PA = PA_W'(PPW);

    logic [PPW-1:0][PIX_W-1:0] mem_q [WORDS];
    logic [PPW-1:0][PIX_W-1:0] word_q;
    logic [SEL_W-1:0]          sel_q;

    // Whole word is read into the output register; the pixel is picked after it,
    // which keeps the array a plain symmetric memory for inference.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        word_q <= mem_q[WA_W'(raddr_i / PPW_PA)];
        sel_q  <= SEL_W'(raddr_i % PPW_PA);
    end

    assign rdata_o = word_q[sel_q];
endmodule

// File: rtl/pixel_fb_dbuf.sv
// Double-buffered HUB75 frame store with a back-bank clear engine; swaps at frame_sync.
// Read latency 1 cycle; wr_ready drops while the clear engine owns the back bank.
module pixel_fb_dbuf
    import led_matrix_pkg::*;
#(
    parameter  int COLS   = DEF_COLS,
    parameter  int ROWS   = DEF_ROWS,
    parameter  int PIX_W  = DEF_PIX_W,
    parameter  int WORD_W = DEF_WORD_W,
    localparam int PPW    = WORD_W / PIX_W,
    localparam int HPIX   = ROWS / 2 * COLS,
    localparam int HWORDS = HPIX / PPW,
    localparam int PA_W   = $clog2(HPIX),
    localparam int WA_W   = $clog2(HWORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PA_W-1:0]   rd_addr_upper,
    output logic [PIX_W-1:0]  dout_upper,
    input  logic [PA_W-1:0]   rd_addr_lower,
    output logic [PIX_W-1:0]  dout_lower,
    input  logic              frame_sync,
    input  logic              wr_en,
    input  logic              wr_half,
    input  logic [WA_W-1:0]   wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              swap_req,
    output logic              swap_pending,
    output logic              swap_done,
    input  logic              clr_req,
    input  logic [PIX_W-1:0]  clr_color,
    output logic              busy,
    output logic              front_sel
);
    clr_state_e        state_q, state_d;
    logic [WA_W-1:0]   cnt_q, cnt_d;
    logic [PIX_W-1:0]  color_q, color_d;
    logic              front_q, pend_q, done_q, front_rd_q, rd_vld_q;
    logic              swap_go;
    logic [WA_W-1:0]   wa;
    logic [WORD_W-1:0] wd;
    logic [PIX_W-1:0]  rd_dat [2][2];

    assign busy         = (state_q == CLEAR);
    assign wr_ready     = ~busy;
    assign swap_pending = pend_q;
    assign swap_done    = done_q;
    assign front_sel    = front_q;
    // A swap_req arriving with frame_sync counts as already pending.
    assign swap_go      = frame_sync && (pend_q || swap_req) && !busy;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        color_d = color_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    color_d = clr_color;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == WA_W'(HWORDS - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            color_q    <= '0;
            front_q    <= 1'b0;
            pend_q     <= 1'b0;
            done_q     <= 1'b0;
            front_rd_q <= 1'b0;
            rd_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            color_q    <= color_d;
            front_q    <= front_q ^ swap_go;
            pend_q     <= swap_go ? 1'b0 : (pend_q | swap_req);
            done_q     <= swap_go;
            front_rd_q <= front_q;
            rd_vld_q   <= 1'b1;
        end
    end

    assign wa = busy ? cnt_q : wr_addr;
    assign wd = busy ? {PPW{color_q}} : wr_data;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        for (genvar h = 0; h < 2; h++) begin : g_half
            logic we;
            assign we = (1'(b) != front_q) && (busy || (wr_en && (wr_half == 1'(h))));

            fb_half_ram #(
                .WORD_W (WORD_W),
                .PIX_W  (PIX_W),
                .WORDS  (HWORDS),
                .WA_W   (WA_W),
                .PA_W   (PA_W)
            ) u_ram (
                .clk_i   (clk),
                .we_i    (we),
                .waddr_i (wa),
                .wdata_i (wd),
                .raddr_i ((h == 0) ? rd_addr_upper : rd_addr_lower),
                .rdata_o (rd_dat[b][h])
            );
        end
    end

    // RAM output registers carry no reset, so outputs are gated until the first read lands.
    assign dout_upper = rd_vld_q ? rd_dat[front_rd_q][0] : '0;
    assign dout_lower = rd_vld_q ? rd_dat[front_rd_q][1] : '0;

    a_rd_upper: assert property (@(posedge clk) disable iff (!rst_n) int'(rd_addr_upper) < HPIX);
    a_rd_lower: assert property (@(posedge clk) disable iff (!rst_n) int'(rd_addr_lower) < HPIX);
    a_wr_addr:  assert property (@(posedge clk) disable iff (!rst_n) !wr_en || (int'(wr_addr) < HWORDS));
endmodule

// File: tb/tb_pixel_fb_dbuf.sv
// Scoreboard bench for pixel_fb_dbuf: a behavioural bank/swap/clear model predicts every output.
module tb_pixel_fb_dbuf;
    import led_matrix_pkg::*;

    localparam int PPW    = 8;
    localparam int HPIX   = 1024;
    localparam int HWORDS = 128;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rd_addr_upper, rd_addr_lower;
    logic [3:0]  dout_upper, dout_lower;
    logic        frame_sync, wr_en, wr_half, wr_ready;
    logic [6:0]  wr_addr;
    logic [31:0] wr_data;
    logic        swap_req, swap_pending, swap_done, clr_req, busy, front_sel;
    logic [3:0]  clr_color;

    always #5 clk = ~clk;

    pixel_fb_dbuf dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rd_addr_upper (rd_addr_upper),
        .dout_upper    (dout_upper),
        .rd_addr_lower (rd_addr_lower),
        .dout_lower    (dout_lower),
        .frame_sync    (frame_sync),
        .wr_en         (wr_en),
        .wr_half       (wr_half),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .swap_req      (swap_req),
        .swap_pending  (swap_pending),
        .swap_done     (swap_done),
        .clr_req       (clr_req),
        .clr_color     (clr_color),
        .busy          (busy),
        .front_sel     (front_sel)
    );

    typedef struct {
        pixel_t eu;
        pixel_t el;
    } exp_t;

    exp_t        sbq[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_mem [2][2][HWORDS];
    logic        m_front, m_pend, m_done;
    int          m_left;
    bit          issued;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic pixel_t mpix(input logic b, input logic h, input int p);
        logic [31:0] w;
        w = m_mem[b][h][p / PPW];
        return w[4 * (p % PPW) +: 4];
    endfunction

    task automatic mreset();
        m_front = 1'b0;
        m_pend  = 1'b0;
        m_done  = 1'b0;
        m_left  = 0;
        issued  = 1'b0;
        sbq.delete();
    endtask

    task automatic rd(input int pu, input int pl);
        rd_addr_upper = 10'(pu);
        rd_addr_lower = 10'(pl);
        sbq.push_back('{mpix(m_front, 1'b0, pu), mpix(m_front, 1'b1, pl)});
        issued = 1'b1;
    endtask

    // Advance the model by the inputs currently driven, clock once, then check everything.
    task automatic cyc();
        logic apply;
        logic back;
        exp_t e;
        apply = frame_sync && (m_pend || swap_req) && (m_left == 0);
        if (wr_en && m_left == 0) m_mem[!m_front][wr_half][wr_addr] = wr_data;
        if (m_left > 0) begin
            m_left--;
        end else if (clr_req) begin
            back = !(m_front ^ apply);
            for (int h = 0; h < 2; h++)
                for (int w = 0; w < HWORDS; w++) m_mem[back][h][w] = {PPW{clr_color}};
            m_left = HWORDS;
        end
        m_pend  = apply ? 1'b0 : (m_pend | swap_req);
        m_front = m_front ^ apply;
        m_done  = apply;
        @(posedge clk);
        #1;
        wr_en = 0; swap_req = 0; frame_sync = 0; clr_req = 0;
        if (issued) begin
            e = sbq.pop_front();
            chk("dout_upper", dout_upper, e.eu);
            chk("dout_lower", dout_lower, e.el);
            issued = 1'b0;
        end
        chk("front_sel", front_sel, m_front);
        chk("swap_pending", swap_pending, m_pend);
        chk("swap_done", swap_done, m_done);
        chk("busy", busy, m_left > 0);
        chk("wr_ready", wr_ready, m_left == 0);
    endtask

    task automatic run_clear(input logic [3:0] c);
        int n;
        clr_req = 1; clr_color = c;
        cyc();
        n = 0;
        while (busy && n < 300) begin
            n++;
            cyc();
        end
        chk("clear_len", n, HWORDS);
    endtask

    task automatic swap_now();
        swap_req = 1; frame_sync = 1;
        cyc();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 0; frame_sync = 0; wr_en = 0; wr_half = 0; wr_addr = '0; wr_data = '0;
        swap_req = 0; clr_req = 0; clr_color = '0; rd_addr_upper = '0; rd_addr_lower = '0;
        for (int b = 0; b < 2; b++)
            for (int h = 0; h < 2; h++)
                for (int w = 0; w < HWORDS; w++) m_mem[b][h][w] = '0;
        mreset();
        #12;
        chk("rst_front_sel", front_sel, 0);
        chk("rst_swap_pending", swap_pending, 0);
        chk("rst_swap_done", swap_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dout_upper", dout_upper, 0);
        chk("rst_dout_lower", dout_lower, 0);
        #1 rst_n = 1;
        cyc();

        // Bring both banks to a known state; the first swap also exercises req+sync together.
        run_clear(4'h0);
        swap_now();
        run_clear(4'h0);
        swap_now();

        // Back-bank write is invisible until swapped in.
        wr_en = 1; wr_half = 0; wr_addr = 7'd0; wr_data = 32'h7654_3210;
        cyc();
        for (int p = 0; p < 8; p++) begin rd(p, p); cyc(); end
        swap_req = 1;
        cyc();
        frame_sync = 1;
        rd(3, 3);
        cyc();
        for (int p = 0; p < 8; p++) begin rd(p, p); cyc(); end

        // Pending swap waits for frame_sync; repeated requests merge.
        swap_req = 1;
        cyc();
        for (int i = 0; i < 100; i++) begin
            if (i % 17 == 0) swap_req = 1;
            cyc();
        end
        frame_sync = 1;
        cyc();
        cyc();

        // Clear with colour 2: swap held off, host write dropped.
        clr_req = 1; clr_color = 4'h2;
        cyc();
        n = 0;
        while (busy && n < 300) begin
            if (n == 3) swap_req = 1;
            if (n == 10) frame_sync = 1;
            if (n == 20) begin
                wr_en = 1; wr_half = 0; wr_addr = 7'd5; wr_data = 32'hFFFF_FFFF;
            end
            n++;
            cyc();
        end
        chk("clear_len", n, HWORDS);
        frame_sync = 1;
        cyc();
        chk("swap_after_clear", swap_done, 1);
        rd(40, 40);
        cyc();
        for (int p = 0; p < HPIX; p++) begin rd(p, HPIX - 1 - p); cyc(); end

        // Reset in the middle of a clear.
        rd(100, 200);
        cyc();
        clr_req = 1; clr_color = 4'h3;
        cyc();
        for (int i = 0; i < 60; i++) cyc();
        chk("dout_pre_reset", dout_upper, mpix(m_front, 1'b0, 100));
        #2 rst_n = 0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_front_sel", front_sel, 0);
        chk("arst_dout_upper", dout_upper, 0);
        chk("arst_dout_lower", dout_lower, 0);
        chk("arst_swap_pending", swap_pending, 0);
        chk("arst_wr_ready", wr_ready, 1);
        mreset();
        #2 rst_n = 1;
        run_clear(4'h5);
        swap_now();
        for (int i = 0; i < 64; i++) begin
            rd($urandom_range(0, HPIX - 1), $urandom_range(0, HPIX - 1));
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pixel_fb_dbuf.md
Name: pixel_fb_dbuf

Overview:
- Parametrised, double-buffered frame store for the HUB75-style LED matrix. Successor to the single-bank upper/lower pixel RAM.
- Holds two complete frames (bank 0 and bank 1). Each bank is split into an upper half and a lower half.
- The scan controller reads pixels from the front bank. The host writes packed pixel words into the back bank.
- Banks swap only at a frame boundary, so the display never tears. A built-in clear engine fills the back bank with one colour.

Parameters:
- COLS, 64: matrix columns.
- ROWS, 32: matrix rows (total). Each half holds ROWS/2 rows.
- PIX_W, 4: bits per pixel.
- WORD_W, 32: width of a host write word. Must be a multiple of PIX_W.
- Derived: PPW = WORD_W/PIX_W (pixels per word); HPIX = ROWS/2*COLS (pixels per half); HWORDS = HPIX/PPW (words per half); PA_W = $clog2(HPIX); WA_W = $clog2(HWORDS).

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- rd_addr_upper  in  PA_W  upper-half pixel address, computed as row*COLS+col.
- dout_upper  out  PIX_W  upper-half pixel from the front bank.
- rd_addr_lower  in  PA_W  lower-half pixel address.
- dout_lower  out  PIX_W  lower-half pixel from the front bank.
- frame_sync  in  1  one-cycle pulse from the scan controller at end of frame.
- wr_en  in  1  host word write request.
- wr_half  in  1  write target: 0 = upper half, 1 = lower half.
- wr_addr  in  WA_W  word address within the half.
- wr_data  in  WORD_W  packed pixels.
- wr_ready  out  1  write accepted this cycle. Low while clearing.
- swap_req  in  1  pulse: request a front/back swap.
- swap_pending  out  1  a swap is queued and not yet applied.
- swap_done  out  1  one-cycle pulse on the cycle the swap takes effect.
- clr_req  in  1  pulse: start filling the back bank.
- clr_color  in  PIX_W  fill colour, sampled on the clr_req cycle.
- busy  out  1  clear engine is active.
- front_sel  out  1  index of the current front bank.

Behaviour:
- Reset (asynchronous, rst_n low):
  - front_sel=0, swap_pending=0, swap_done=0, busy=0.
  - dout_upper=0, dout_lower=0.
  - FSM goes to IDLE. wr_ready=1 after reset is released.
  - Memory contents are not reset.
  - A reset during a clear aborts it; the back bank is left partially filled.
- Pixel packing: pixel p is stored in word p/PPW, bits [PIX_W*(p%PPW) +: PIX_W]. Pixel 0 is the LSBs.
- Read path:
  - Synchronous, 1-cycle latency. dout_* reflects the address from the previous cycle, read from the bank that was front_sel on that cycle.
  - Reads are always from the front bank. A read never returns back-bank data.
- Write path:
  - A word is written when wr_en && wr_ready, into bank ~front_sel at (wr_half, wr_addr).
  - While busy, wr_ready=0 and writes are dropped with no side effect.
- Swap:
  - swap_req sets swap_pending.
  - Further swap_req pulses while pending are merged; only one swap occurs.
  - The swap is applied on the first frame_sync with swap_pending=1 and busy=0. On that cycle front_sel toggles on the next edge, swap_done pulses, and swap_pending clears.
  - A read issued in the frame_sync cycle still uses the old bank.
  - swap_req and frame_sync in the same cycle while idle and not pending: the swap is applied on that same frame_sync.
- Clear FSM, states IDLE and CLEAR:
  - IDLE→CLEAR on clr_req: latch clr_color, counter=0, busy=1.
  - CLEAR: each cycle writes {PPW{colour}} to word=counter in both halves of the back bank, then counter increments.
  - After counter==HWORDS-1 is written, the FSM returns to IDLE and busy=0 on the following cycle. A clear takes exactly HWORDS cycles.
  - clr_req while in CLEAR is ignored.
  - A clear targets the bank that is back when it starts. No swap can occur mid-clear, because swaps are held off while busy.
  - clr_req and wr_en in the same IDLE cycle: the write is accepted (wr_ready is still 1) and is then overwritten by the clear.
- Addresses out of range (≥HPIX or ≥HWORDS, which only occurs with non-power-of-2 parameters) are undefined. Assert this in simulation.

Decomposition:
- Package led_matrix_pkg holds:
  - the default COLS/ROWS/PIX_W/WORD_W constants;
  - the clear-FSM state enum typedef (IDLE, CLEAR);
  - a pixel_t typedef, logic [PIX_W-1:0].
- One sub-module, fb_half_ram: simple-dual-port memory with WORD_W write and PIX_W read, 1-cycle read. It is written behaviourally so it infers BRAM.
- The top instantiates four fb_half_ram: 2 banks × 2 halves. It muxes read data by a registered copy of front_sel.

Test Plan:
- Reset, then write word 0x76543210 to the upper half at addr 0 with front_sel=0, then read pixels 0..7 of the upper half → dout_upper=0 for all of them. Swap at frame_sync, then read again → dout_upper=0,1,2,…,7.
- Pulse swap_req with no frame_sync for 100 cycles → swap_pending=1 and front_sel=0 throughout. frame_sync pulse → swap_done high for 1 cycle, front_sel=1, swap_pending=0.
- clr_req with clr_color=4'h2 (default params, HWORDS=128) → busy=1 for exactly 128 cycles and wr_ready=0 during that time. After a swap, every read in both halves → 2.
- Clear is running and frame_sync arrives while swap_pending=1 → no swap. First frame_sync after busy falls → swap occurs.
- Attempt a write during the clear at addr 5 with data 0xFFFFFFFF → dropped. Pixel 40 still reads the clear colour.
- Drop rst_n mid-clear at counter=60 → busy=0, front_sel=0, dout=0 asynchronously. After release, a new clear completes in 128 cycles.
